// File: rtl/priority_encoder_seq_if.sv
// Handshake bundle for priority_encoder_seq.
//   in_valid/in_ready/in_req  : request word channel (upstream -> encoder)
//   out_valid/out_ready       : index beat channel (encoder -> downstream)
//   out_idx/out_last/out_none : beat payload
// slave  : the encoder's view (accepts requests, produces beats)
// master : the environment's view (produces requests, consumes beats)
interface priority_encoder_seq_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_req;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_none;

  modport slave (
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none
  );

  modport master (
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none
  );
endinterface

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder. Accepts an N-bit request word and emits the
// index of every set bit, highest first, one beat per out handshake. An
// all-zero word yields a single beat flagged out_none.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of priority_encoder_seq_if (request in, index beats out)
module priority_encoder_seq #(
  parameter int unsigned N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  priority_encoder_seq_if.slave  bus
);
  localparam int unsigned IW = $clog2(N);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic          none_q, none_d;

  logic [IW-1:0] hi_idx;
  logic          single;
  logic          emit;

  // Highest set bit of pending; stays 0 for an empty word.
  always_comb begin
    hi_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending_q[i]) hi_idx = i[IW-1:0];
    end
  end

  assign single = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
  assign emit   = (state_q == StEmit);

  // Outputs come from registered state only; rst gates in_ready directly so
  // nothing is accepted while reset is held.
  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = emit;
  assign bus.out_idx   = emit ? hi_idx : '0;
  assign bus.out_last  = emit && (none_q || single);
  assign bus.out_none  = emit && none_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = none_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          pending_d = bus.in_req;
          none_d    = (bus.in_req == '0);
          state_d   = StEmit;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          pending_d         = pending_q;
          pending_d[hi_idx] = 1'b0;
          if (none_q || single) begin
            pending_d = '0;
            none_d    = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end
endmodule

// File: tb/tb_priority_encoder_seq.sv
module tb_priority_encoder_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  priority_encoder_seq_if #(.N(4)) bus ();

  priority_encoder_seq #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    int unsigned n;     // expected beat count
    logic [7:0]  idxs;  // expected indices, first beat in [7:6]
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then applies one request and checks all beats.
  task automatic run_req(input logic [3:0] req, input int unsigned n, input logic [7:0] idxs);
    logic [7:0] sh;
    int         w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    check("idle_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_req    = req;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    sh = idxs;
    for (int unsigned b = 0; b < n; b++) begin
      check("beat_valid", {31'd0, bus.out_valid}, 32'd1);
      check("beat_idx", {30'd0, bus.out_idx}, {30'd0, sh[7:6]});
      check("beat_last", {31'd0, bus.out_last}, (b == n - 1) ? 32'd1 : 32'd0);
      check("beat_none", {31'd0, bus.out_none}, (req == 4'b0) ? 32'd1 : 32'd0);
      check("busy_ready", {31'd0, bus.in_ready}, 32'd0);
      sh = sh << 2;
      step();
    end
    check("end_valid", {31'd0, bus.out_valid}, 32'd0);
    check("turn_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{req: 4'b1011, n: 3, idxs: {2'd3, 2'd1, 2'd0, 2'd0}};
    vecs[1] = '{req: 4'b0000, n: 1, idxs: {2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[2] = '{req: 4'b1111, n: 4, idxs: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[3] = '{req: 4'b0100, n: 1, idxs: {2'd2, 2'd0, 2'd0, 2'd0}};
    vecs[4] = '{req: 4'b1001, n: 2, idxs: {2'd3, 2'd0, 2'd0, 2'd0}};
    vecs[5] = '{req: 4'b0011, n: 2, idxs: {2'd1, 2'd0, 2'd0, 2'd0}};

    // Reset held with a pending request: nothing accepted, outputs quiet.
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_req    = 4'b1010;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_idx", {30'd0, bus.out_idx}, 32'd0);
    check("rst_last", {31'd0, bus.out_last}, 32'd0);
    check("rst_none", {31'd0, bus.out_none}, 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

    for (int v = 0; v < 6; v++) run_req(vecs[v].req, vecs[v].n, vecs[v].idxs);

    // Backpressure: beat held stable while out_ready is low.
    bus.in_valid  = 1'b1;
    bus.in_req    = 4'b0110;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_idx", {30'd0, bus.out_idx}, 32'd2);
      check("bp_last", {31'd0, bus.out_last}, 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    check("bp_idx_rel", {30'd0, bus.out_idx}, 32'd2);
    step();
    check("bp_idx2", {30'd0, bus.out_idx}, 32'd1);
    check("bp_last2", {31'd0, bus.out_last}, 32'd1);
    step();
    check("bp_done", {31'd0, bus.out_valid}, 32'd0);

    // New word offered while busy must be ignored until back in idle.
    bus.in_valid  = 1'b1;
    bus.in_req    = 4'b1000;
    bus.out_ready = 1'b0;
    step();
    bus.in_req = 4'b0111;
    step();
    check("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("busy_idx", {30'd0, bus.out_idx}, 32'd3);
    check("busy_last", {31'd0, bus.out_last}, 32'd1);
    bus.out_ready = 1'b1;
    step();
    check("busy_back_idle", {31'd0, bus.out_valid}, 32'd0);
    check("busy_back_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("held_idx0", {30'd0, bus.out_idx}, 32'd2);
    step();
    check("held_idx1", {30'd0, bus.out_idx}, 32'd1);
    step();
    check("held_idx2", {30'd0, bus.out_idx}, 32'd0);
    check("held_last", {31'd0, bus.out_last}, 32'd1);
    step();
    check("held_done", {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of a burst abandons the remaining beats.
    bus.in_valid = 1'b1;
    bus.in_req   = 4'b1111;
    step();
    bus.in_valid = 1'b0;
    check("mid_idx3", {30'd0, bus.out_idx}, 32'd3);
    step();
    check("mid_idx2", {30'd0, bus.out_idx}, 32'd2);
    rst = 1'b1;
    #1;
    check("mid_async_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("mid_no_beats", {31'd0, bus.out_valid}, 32'd0);
    end
    run_req(4'b0001, 1, {2'd0, 2'd0, 2'd0, 2'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
